// File: rtl/bcd_event_counter.sv
// Multi-channel push-button event counter: per-channel sync, debounce and edge
// detect feeding N_DIGITS-digit BCD counters with overflow policy and snapshot.
module bcd_event_counter #(
  parameter int N_CH            = 4,
  parameter int N_DIGITS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SAT_MODE        = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     snap,
  input  logic [N_CH-1:0]          button,
  output logic [N_CH*N_DIGITS*4-1:0] digits,
  output logic [N_CH*N_DIGITS*4-1:0] snap_digits,
  output logic [N_CH-1:0]          overflow,
  output logic [N_CH-1:0]          event_pulse
);

  localparam int W = N_DIGITS * 4;

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] stable_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] inc;
  logic [N_CH-1:0] all_nines;
  logic [W-1:0]    next_count [N_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_db
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) stable <= '0;
        else        stable <= sync2;
      end
    end else begin : g_db
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] db_cnt [N_CH];

      // A channel's level only moves once s2 has disagreed for the full window.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stable <= '0;
          for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < N_CH; i++) begin
            if (sync2[i] == stable[i]) begin
              db_cnt[i] <= '0;
            end else if (db_cnt[i] == LAST) begin
              stable[i] <= sync2[i];
              db_cnt[i] <= '0;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stable_d <= '0;
    else        stable_d <= stable;
  end

  assign rise = stable & ~stable_d;
  assign inc  = rise & {N_CH{enable}};

  // Ripple-carry BCD increment; a carry out of the top digit marks overflow.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    carry     = 1'b0;
    d         = 4'd0;
    all_nines = '0;
    for (int i = 0; i < N_CH; i++) begin
      next_count[i] = '0;
      carry = 1'b1;
      for (int k = 0; k < N_DIGITS; k++) begin
        d = digits[i*W + k*4 +: 4];
        if (carry) begin
          if (d == 4'd9) begin
            d = 4'd0;
          end else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end
        next_count[i][k*4 +: 4] = d;
      end
      all_nines[i] = carry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= '0;
      overflow    <= '0;
      event_pulse <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clear) begin
          digits[i*W +: W] <= '0;
          overflow[i]      <= 1'b0;
          event_pulse[i]   <= 1'b0;
        end else if (inc[i]) begin
          event_pulse[i] <= 1'b1;
          if (all_nines[i]) overflow[i] <= 1'b1;
          // Saturating channels hold all-9s; wrapping ones take the zeroed sum.
          if (!(all_nines[i] && (SAT_MODE != 0))) digits[i*W +: W] <= next_count[i];
        end else begin
          event_pulse[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    snap_digits <= '0;
    else if (snap) snap_digits <= digits;
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Directed self-checking bench: a default-parameter DUT for timing/debounce
// behaviour plus two small 2-digit DUTs (wrap and saturate) for overflow.
module tb_bcd_event_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        snap;
  logic [3:0]  button;
  logic [63:0] digits;
  logic [63:0] snap_digits;
  logic [3:0]  overflow;
  logic [3:0]  event_pulse;

  logic        button_s;
  logic [7:0]  digits_w, snap_w, digits_s, snap_s;
  logic        ovf_w, ev_w, ovf_s, ev_s;

  int checks = 0;
  int errors = 0;

  bcd_event_counter #(.N_CH(4), .N_DIGITS(4), .DEBOUNCE_CYCLES(4), .SAT_MODE(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .snap(snap),
    .button(button), .digits(digits), .snap_digits(snap_digits),
    .overflow(overflow), .event_pulse(event_pulse)
  );

  bcd_event_counter #(.N_CH(1), .N_DIGITS(2), .DEBOUNCE_CYCLES(0), .SAT_MODE(0)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .snap(snap),
    .button(button_s), .digits(digits_w), .snap_digits(snap_w),
    .overflow(ovf_w), .event_pulse(ev_w)
  );

  bcd_event_counter #(.N_CH(1), .N_DIGITS(2), .DEBOUNCE_CYCLES(0), .SAT_MODE(1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .snap(snap),
    .button(button_s), .digits(digits_s), .snap_digits(snap_s),
    .overflow(ovf_s), .event_pulse(ev_s)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a posedge; returns 1 time unit after the posedge
  // at which the released level has settled through the debouncer.
  task automatic press_main(input int ch);
    button[ch] = 1'b1;
    repeat (6) @(posedge clk);
    #1 button[ch] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic press_small(output int pw, output int ps);
    pw = 0;
    ps = 0;
    button_s = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) button_s = 1'b0;
      if (ev_w) pw++;
      if (ev_s) ps++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (digits !== 64'h0) begin errors++; $display("[TB] FAIL reset_digits: got %h expected %h", digits, 64'h0); end
    checks++; if (snap_digits !== 64'h0) begin errors++; $display("[TB] FAIL reset_snap: got %h expected %h", snap_digits, 64'h0); end
    checks++; if (overflow !== 4'h0) begin errors++; $display("[TB] FAIL reset_overflow: got %h expected %h", overflow, 4'h0); end
    checks++; if (event_pulse !== 4'h0) begin errors++; $display("[TB] FAIL reset_event: got %h expected %h", event_pulse, 4'h0); end
    checks++; if ({digits_w, digits_s, ovf_w, ovf_s} !== 18'h0) begin errors++; $display("[TB] FAIL reset_small: got %h expected %h", {digits_w, digits_s, ovf_w, ovf_s}, 18'h0); end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Press applied just after edge E0; the count must land exactly at E7.
  task automatic test_single_press;
    logic [63:0] exp_d;
    logic [3:0]  exp_e;
    button[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      exp_d = (e >= 7) ? 64'h1 : 64'h0;
      exp_e = (e == 7) ? 4'b0001 : 4'b0000;
      checks++; if (digits !== exp_d) begin errors++; $display("[TB] FAIL latency_digits E%0d: got %h expected %h", e, digits, exp_d); end
      checks++; if (event_pulse !== exp_e) begin errors++; $display("[TB] FAIL latency_event E%0d: got %b expected %b", e, event_pulse, exp_e); end
    end
    repeat (12) @(posedge clk);
    #1 button[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (digits !== 64'h1) begin errors++; $display("[TB] FAIL hold_single_count: got %h expected %h", digits, 64'h1); end
  endtask

  task automatic test_glitch;
    int pulses;
    pulses = 0;
    button[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 button[1] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (event_pulse[1]) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL glitch3_event: got %0d expected %0d", pulses, 0); end
    checks++; if (digits[31:16] !== 16'h0000) begin errors++; $display("[TB] FAIL glitch3_digits: got %h expected %h", digits[31:16], 16'h0000); end
    pulses = 0;
    button[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1 button[1] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (event_pulse[1]) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL pulse4_event: got %0d expected %0d", pulses, 1); end
    checks++; if (digits[31:16] !== 16'h0001) begin errors++; $display("[TB] FAIL pulse4_digits: got %h expected %h", digits[31:16], 16'h0001); end
  endtask

  task automatic test_carry;
    repeat (8) press_main(0);
    checks++; if (digits[15:0] !== 16'h0009) begin errors++; $display("[TB] FAIL carry_0009: got %h expected %h", digits[15:0], 16'h0009); end
    press_main(0);
    checks++; if (digits[15:0] !== 16'h0010) begin errors++; $display("[TB] FAIL carry_0010: got %h expected %h", digits[15:0], 16'h0010); end
    repeat (89) press_main(0);
    checks++; if (digits[15:0] !== 16'h0099) begin errors++; $display("[TB] FAIL carry_0099: got %h expected %h", digits[15:0], 16'h0099); end
    press_main(0);
    checks++; if (digits[15:0] !== 16'h0100) begin errors++; $display("[TB] FAIL carry_0100: got %h expected %h", digits[15:0], 16'h0100); end
    checks++; if (overflow !== 4'h0) begin errors++; $display("[TB] FAIL carry_no_overflow: got %h expected %h", overflow, 4'h0); end
  endtask

  task automatic test_overflow;
    int pw, ps;
    repeat (99) press_small(pw, ps);
    checks++; if ({digits_w, digits_s} !== 16'h9999) begin errors++; $display("[TB] FAIL ovf_preload: got %h expected %h", {digits_w, digits_s}, 16'h9999); end
    checks++; if ({ovf_w, ovf_s} !== 2'b00) begin errors++; $display("[TB] FAIL ovf_preload_flag: got %b expected %b", {ovf_w, ovf_s}, 2'b00); end
    press_small(pw, ps);
    checks++; if (digits_w !== 8'h00) begin errors++; $display("[TB] FAIL wrap_digits: got %h expected %h", digits_w, 8'h00); end
    checks++; if (ovf_w !== 1'b1) begin errors++; $display("[TB] FAIL wrap_overflow: got %b expected %b", ovf_w, 1'b1); end
    checks++; if (digits_s !== 8'h99) begin errors++; $display("[TB] FAIL sat_digits: got %h expected %h", digits_s, 8'h99); end
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("[TB] FAIL sat_overflow: got %b expected %b", ovf_s, 1'b1); end
    checks++; if ({pw[3:0], ps[3:0]} !== 8'h11) begin errors++; $display("[TB] FAIL ovf_event_pulses: got %0d/%0d expected 1/1", pw, ps); end
    press_small(pw, ps);
    checks++; if ({digits_w, ovf_w} !== 9'h003) begin errors++; $display("[TB] FAIL wrap_sticky: got %h expected %h", {digits_w, ovf_w}, 9'h003); end
    checks++; if ({digits_s, ovf_s} !== 9'h133) begin errors++; $display("[TB] FAIL sat_hold: got %h expected %h", {digits_s, ovf_s}, 9'h133); end
  endtask

  task automatic test_enable;
    enable = 1'b0;
    press_main(2);
    enable = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (digits !== 64'h0000_0000_0001_0100) begin errors++; $display("[TB] FAIL enable_discard: got %h expected %h", digits, 64'h0000_0000_0001_0100); end
  endtask

  task automatic test_clear_snap;
    repeat (5) press_main(3);
    checks++; if (digits[63:48] !== 16'h0005) begin errors++; $display("[TB] FAIL preload_ch3: got %h expected %h", digits[63:48], 16'h0005); end
    button[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1 clear = 1'b1; snap = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; snap = 1'b0;
    checks++; if (digits !== 64'h0) begin errors++; $display("[TB] FAIL clear_digits: got %h expected %h", digits, 64'h0); end
    checks++; if (event_pulse !== 4'h0) begin errors++; $display("[TB] FAIL clear_event: got %b expected %b", event_pulse, 4'h0); end
    checks++; if (snap_digits !== 64'h0005_0000_0001_0100) begin errors++; $display("[TB] FAIL snap_preclear: got %h expected %h", snap_digits, 64'h0005_0000_0001_0100); end
    checks++; if ({overflow, ovf_w, ovf_s, digits_w} !== 14'h0) begin errors++; $display("[TB] FAIL clear_overflow: got %h expected %h", {overflow, ovf_w, ovf_s, digits_w}, 14'h0); end
    repeat (4) @(posedge clk);
    #1 button[3] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (digits !== 64'h0) begin errors++; $display("[TB] FAIL clear_edge_lost: got %h expected %h", digits, 64'h0); end
    checks++; if (snap_digits !== 64'h0005_0000_0001_0100) begin errors++; $display("[TB] FAIL snap_kept: got %h expected %h", snap_digits, 64'h0005_0000_0001_0100); end
  endtask

  task automatic test_back_to_back;
    button[1] = 1'b1;
    button[2] = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (event_pulse !== 4'b0110) begin errors++; $display("[TB] FAIL multi_event: got %b expected %b", event_pulse, 4'b0110); end
    checks++; if (digits !== 64'h0000_0001_0001_0000) begin errors++; $display("[TB] FAIL multi_digits: got %h expected %h", digits, 64'h0000_0001_0001_0000); end
    button[1] = 1'b0;
    button[2] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] exp_d;
    logic [3:0]  exp_e;
    button[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if ({digits, snap_digits, overflow, event_pulse} !== 136'h0) begin errors++; $display("[TB] FAIL reset_async: got %h/%h expected 0", digits, snap_digits); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({digits, snap_digits, overflow, event_pulse} !== 136'h0) begin errors++; $display("[TB] FAIL reset_held: got %h/%h expected 0", digits, snap_digits); end
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      exp_d = (e >= 7) ? 64'h1 : 64'h0;
      exp_e = (e == 7) ? 4'b0001 : 4'b0000;
      checks++; if (digits !== exp_d) begin errors++; $display("[TB] FAIL postreset_digits E%0d: got %h expected %h", e, digits, exp_d); end
      checks++; if (event_pulse !== exp_e) begin errors++; $display("[TB] FAIL postreset_event E%0d: got %b expected %b", e, event_pulse, exp_e); end
    end
    button[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (digits !== 64'h1) begin errors++; $display("[TB] FAIL postreset_once: got %h expected %h", digits, 64'h1); end
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    snap     = 1'b0;
    button   = 4'h0;
    button_s = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_carry();
    test_overflow();
    test_enable();
    test_clear_snap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
